// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

    // Default operand width, shared by the board top, the controller and the bench.
    localparam int WIDTH_DEF = 4;

    // Controller states; the encoding is private to the controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (switches/button or test FSM) and the serial adder.
// Latency: n/a (wires only).
// Backpressure: start/busy/done handshake; the requester holds start until busy or done says accepted.
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::WIDTH_DEF
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side: drives operands and start, observes status and result.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    // Adder side: consumes operands and start, reports status and result.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output sum,
        output cout
    );

endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// One-bit full adder slice, reused every cycle by the serial controller.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ cin;
    assign co = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: steps one full-adder slice over WIDTH cycles, LSB first, carry held between cycles.
// Latency: start accepted at edge E0, sum/cout/done valid right after edge E0+WIDTH.
// Backpressure: start ignored while busy; done holds until the next accepted start.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic              clk,
    input logic              rst,
    serial_add_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    // FSM decodes that steer the datapath.
    logic             load;
    logic             step;
    logic             last;

    // Operand shift registers, partial sum, carry and bit index.
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ps_nxt;
    logic             carry;
    logic [CNT_W-1:0] idx;

    // Result registers; only updated on the final RUN edge.
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Slice outputs for the current bit.
    logic             slice_s;
    logic             slice_co;

    fa_bit u_fa (
        .a   (sa[0]),
        .b   (sb[0]),
        .cin (carry),
        .s   (slice_s),
        .co  (slice_co)
    );

    // New sum bit enters at the MSB; after WIDTH steps bit 0 lands in ps[0].
    assign ps_nxt = (ps >> 1) | {slice_s, {(WIDTH-1){1'b0}}};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control; DONE accepts start exactly like IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and per-bit shifting; idx is parked at zero after the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (load) begin
            sa    <= bus.a;
            sb    <= bus.b;
            carry <= 1'b0;
            idx   <= '0;
        end else if (step) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            ps    <= ps_nxt;
            carry <= slice_co;
            idx   <= last ? '0 : idx + 1'b1;
        end
    end

    // Result capture; holds the previous answer for the whole of the next RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (last) begin
            sum_q  <= ps_nxt;
            cout_q <= slice_co;
        end
    end

    // Status is decoded from registered state only.
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=4 and WIDTH=2.
// Latency: expected result due WIDTH+1 edges after the start is driven.
// Backpressure: none; monitors pop on each rising done.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W4 = WIDTH_DEF;
    localparam int W2 = 2;

    typedef struct {
        logic [4:0] val;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst4;
    logic rst2;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t exp4[$];
    exp_t exp2[$];
    exp_t e4;
    exp_t e2;
    logic done4_q = 1'b0;
    logic done2_q = 1'b0;

    serial_add_ctrl_if #(.WIDTH(W4)) bus4 ();
    serial_add_ctrl_if #(.WIDTH(W2)) bus2 ();

    serial_add_ctrl #(.WIDTH(W4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    serial_add_ctrl #(.WIDTH(W2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the 4-bit instance: each rising done retires one expected result.
    always @(negedge clk) begin
        if (bus4.done && !done4_q) begin
            check("dut4_done_expected", 32'(exp4.size() != 0), 1);
            if (exp4.size() != 0) begin
                e4 = exp4.pop_front();
                check("dut4_sum", 32'(bus4.sum), 32'(e4.val[3:0]));
                check("dut4_cout", 32'(bus4.cout), 32'(e4.val[4]));
                check("dut4_done_cycle", cyc, e4.due);
            end
        end
        done4_q <= bus4.done;
    end

    // Monitor for the 2-bit instance.
    always @(negedge clk) begin
        if (bus2.done && !done2_q) begin
            check("dut2_done_expected", 32'(exp2.size() != 0), 1);
            if (exp2.size() != 0) begin
                e2 = exp2.pop_front();
                check("dut2_sum", 32'(bus2.sum), 32'(e2.val[1:0]));
                check("dut2_cout", 32'(bus2.cout), 32'(e2.val[2]));
                check("dut2_done_cycle", cyc, e2.due);
            end
        end
        done2_q <= bus2.done;
    end

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input bit push);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        if (push) exp4.push_back('{val: 5'(a) + 5'(b), due: cyc + 1 + W4});
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic issue2(input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.a     = a;
        bus2.b     = b;
        exp2.push_back('{val: 5'(a) + 5'(b), due: cyc + 1 + W2});
        @(negedge clk);
        bus2.start = 1'b0;
    endtask

    task automatic wait_done4();
        int n = 0;
        while (!bus4.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("dut4_done_seen", 32'(bus4.done), 1);
    endtask

    task automatic wait_done2();
        int n = 0;
        while (!bus2.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("dut2_done_seen", 32'(bus2.done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
        rst4 = 1'b0;
        rst2 = 1'b0;
        #2;
        rst4 = 1'b1;
        rst2 = 1'b1;
        #2;
        check("rst_busy", 32'(bus4.busy), 0);
        check("rst_done", 32'(bus4.done), 0);
        check("rst_sum", 32'(bus4.sum), 0);
        check("rst_cout", 32'(bus4.cout), 0);
        check("rst2_done", 32'(bus2.done), 0);
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus4.busy), 0);
        check("idle_done", 32'(bus4.done), 0);

        // 3 + 5: busy for exactly four cycles, then done holds with start low.
        issue4(4'd3, 4'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t1_busy", 32'(bus4.busy), 1);
            check("t1_done_low", 32'(bus4.done), 0);
            @(negedge clk);
        end
        check("t1_done", 32'(bus4.done), 1);
        check("t1_busy_low", 32'(bus4.busy), 0);
        repeat (3) @(negedge clk);
        check("t1_done_hold", 32'(bus4.done), 1);
        check("t1_sum_hold", 32'(bus4.sum), 8);

        // 15 + 1 overflows into cout; then 15 + 15 restarted from DONE.
        issue4(4'd15, 4'd1, 1'b1);
        wait_done4();
        issue4(4'd15, 4'd15, 1'b1);
        check("t2_done_drop", 32'(bus4.done), 0);
        check("t2_cout_old", 32'(bus4.cout), 1);
        check("t2_sum_run", 32'(bus4.sum), 0);
        repeat (3) begin
            @(negedge clk);
            check("t2_sum_run", 32'(bus4.sum), 0);
        end
        wait_done4();

        // start held high: three back-to-back 6 + 7 operations, one every five cycles.
        @(negedge clk);
        c = cyc;
        bus4.start = 1'b1;
        bus4.a     = 4'd6;
        bus4.b     = 4'd7;
        exp4.push_back('{val: 5'd13, due: c + 5});
        exp4.push_back('{val: 5'd13, due: c + 10});
        exp4.push_back('{val: 5'd13, due: c + 15});
        repeat (12) @(negedge clk);
        bus4.start = 1'b0;
        wait_done4();
        @(negedge clk);
        check("t3_done_hold", 32'(bus4.done), 1);

        // 9 + 4 with start toggling and operands zeroed during RUN.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 4'd9;
        bus4.b     = 4'd4;
        exp4.push_back('{val: 5'd13, due: cyc + 1 + W4});
        @(negedge clk);
        bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0;
        @(negedge clk);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'd15;
        @(negedge clk);
        bus4.start = 1'b0;
        check("t4_done", 32'(bus4.done), 1);

        // Leave a nonzero result with cout set, then abort a run with async reset.
        issue4(4'd15, 4'd15, 1'b1);
        wait_done4();
        issue4(4'd1, 4'd1, 1'b0);
        @(posedge clk);
        #2;
        rst4 = 1'b1;
        #1;
        check("t5_busy", 32'(bus4.busy), 0);
        check("t5_done", 32'(bus4.done), 0);
        check("t5_sum", 32'(bus4.sum), 0);
        check("t5_cout", 32'(bus4.cout), 0);
        @(negedge clk);
        rst4 = 1'b0;
        issue4(4'd2, 4'd2, 1'b1);
        wait_done4();

        // WIDTH=2: 3 + 3, then every operand pair.
        issue2(2'd3, 2'd3);
        wait_done2();
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                issue2(2'(a), 2'(b));
                wait_done2();
            end
        end

        repeat (3) @(negedge clk);
        check("dut4_queue_drained", exp4.size(), 0);
        check("dut2_queue_drained", exp2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single one-bit full-adder slice over WIDTH clock cycles to add two WIDTH-bit operands, LSB first, with a carry register between cycles. It replaces a wide ripple adder on the Nexys4 DDR switch/LED designs: operands come from slide switches, the start request comes from a button, and sum/cout drive LEDs. A start/busy/done handshake lets a top level or test FSM reuse the one slice for repeated additions.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..16).
- CNT_W, $clog2(WIDTH), width of the internal bit-index counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request, sampled on the clock; level-sensitive.
- a  input  WIDTH  operand A, captured only when start is accepted.
- b  input  WIDTH  operand B, captured only when start is accepted.
- busy  output  1  high while the operation is in RUN.
- done  output  1  high in DONE; holds until the next accepted start.
- sum  output  WIDTH  registered result; changes only on entry to DONE.
- cout  output  1  registered carry-out of the MSB; changes only on entry to DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Operand shift registers, carry register, partial-sum shift register and bit counter are all cleared.
- States: IDLE, RUN, DONE. The state encoding is internal.
- IDLE:
  - With start=1 at a clock edge: load a→sa and b→sb, clear carry, set idx=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Slice inputs are sa[0], sb[0] and carry.
  - Shift the slice sum into the MSB of the partial register ps (ps <= {s, ps[WIDTH-1:1]}).
  - Shift sa and sb right by one; carry <= slice carry-out; idx <= idx+1.
  - On the edge where idx==WIDTH-1: additionally write sum <= final ps value (including this bit) and cout <= slice carry-out, then go to DONE.
- DONE:
  - With start=1: behave exactly as IDLE with start, so back-to-back operations are allowed.
  - sum and cout keep their old values until the new operation reaches DONE.
  - With start=0: stay in DONE.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, so there is no combinational path from inputs to outputs.
- Latency: start is accepted at edge E0. Bits are computed on edges E1..EWIDTH. done=1 and sum/cout are valid immediately after edge EWIDTH. With start held high, a new operation is accepted every WIDTH+1 cycles.
- start in RUN is ignored. Changes on a or b during RUN have no effect.
- Arithmetic: {cout,sum} = a + b, unsigned, mod 2^(WIDTH+1). Overflow is fully captured by cout.
- Reset asserted mid-RUN aborts immediately: all registers go to their reset values and the partial result is discarded.
- idx never exceeds WIDTH-1. Wrap-around of idx is unreachable, because idx is reloaded on every accepted start.

Decomposition:
- Shared package (serial_add_pkg) holds:
  - the state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the WIDTH default constant, shared with the board top and the bench.
- One natural sub-module, fa_bit: a purely combinational one-bit full adder.
  - Ports: a, b, cin, s, co.
  - s = a^b^cin; co = (a&b)|(cin&(a^b)).
  - Instantiated once in the controller and unit-tested separately.

Test Plan:
- WIDTH=4, a=3, b=5, pulse start one cycle → busy high for 4 cycles; on the 4th edge after start, done=1, sum=8, cout=0; done stays high with start low.
- WIDTH=4, a=15, b=1 → sum=0, cout=1. Then a=15, b=15 with a new start from DONE → done drops the next cycle, sum stays 0 during RUN, final sum=14, cout=1.
- start held high continuously with a=6, b=7 → done pulses one cycle every 5 cycles, with sum=13, cout=0 each time.
- Accepted start with a=9, b=4; during RUN, toggle start and change a=0, b=0 → result still sum=13, cout=0, and done appears exactly 4 edges after the original accept.
- Assert rst asynchronously (mid-cycle) during the 2nd RUN cycle → busy, done, sum and cout go to 0 immediately without waiting for a clock edge. A subsequent start with a=2, b=2 gives sum=4, cout=0.
- WIDTH=2 instance, a=3, b=3 → sum=2, cout=1 after 2 cycles. Exhaustively sweep all 16 a/b pairs against a+b.
